// File: rtl/dptr_pipe.sv
// Three-stage (IF / EX / WB) single-issue datapath with a loadable instruction
// memory, a 32-entry register file, WB->EX forwarding and halt handling.
module dptr_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  output logic [IMEM_AW-1:0] pc,
  output logic               wb_en,
  output logic [4:0]         wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               halted,
  output logic [7:0]         err_cnt
);

  localparam int DEPTH = 1 << IMEM_AW;

  logic [31:0]       imem [DEPTH];
  logic [DATA_W-1:0] rf [32];

  // IR keeps only the decoded fields: {opcode, rs, rt, rd, funct}; shamt is dropped.
  logic [26:0]       ir;
  logic              ir_valid;
  logic              ex_we;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_data;

  logic              adv;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              funct_ok;
  logic              dec_alu;
  logic              dec_halt;
  logic              dec_illegal;

  always_ff @(posedge clk) begin
    if (imem_we && !run) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  always_comb begin
    adv    = run & ~halted;
    opcode = ir[26:21];
    rs     = ir[20:16];
    rt     = ir[15:11];
    rd     = ir[10:6];
    funct  = ir[5:0];

    // The result being written back this edge is newer than the register file.
    if (rs == 5'd0) begin
      op_a = '0;
    end else if (ex_we && (ex_rd == rs)) begin
      op_a = ex_data;
    end else begin
      op_a = rf[rs];
    end
    if (rt == 5'd0) begin
      op_b = '0;
    end else if (ex_we && (ex_rd == rt)) begin
      op_b = ex_data;
    end else begin
      op_b = rf[rt];
    end

    funct_ok = 1'b1;
    case (funct)
      6'h20:   alu_res = op_a + op_b;
      6'h22:   alu_res = op_a - op_b;
      6'h24:   alu_res = op_a & op_b;
      6'h25:   alu_res = op_a | op_b;
      6'h27:   alu_res = ~(op_a | op_b);
      6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: begin
        alu_res  = '0;
        funct_ok = 1'b0;
      end
    endcase

    dec_alu     = ir_valid & (opcode == 6'h00) & funct_ok;
    dec_halt    = ir_valid & (opcode == 6'h3F);
    dec_illegal = ir_valid & ~dec_alu & ~dec_halt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_rd    <= 5'd0;
      ex_data  <= '0;
      wb_en    <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
      halted   <= 1'b0;
      err_cnt  <= 8'd0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (adv) begin
      pc <= pc + IMEM_AW'(1);
      // A halt in EX squashes the word fetched alongside it.
      if (dec_halt) begin
        ir       <= '0;
        ir_valid <= 1'b0;
        halted   <= 1'b1;
      end else begin
        ir       <= {imem[pc][31:11], imem[pc][5:0]};
        ir_valid <= 1'b1;
      end

      ex_we <= dec_alu;
      if (dec_alu) begin
        ex_rd   <= rd;
        ex_data <= alu_res;
      end else begin
        ex_rd   <= ex_rd;
        ex_data <= ex_data;
      end

      wb_en <= ex_we;
      if (ex_we) begin
        wb_addr <= ex_rd;
        wb_data <= ex_data;
        if (ex_rd != 5'd0) begin
          rf[ex_rd] <= ex_data;
        end
      end else begin
        wb_addr <= wb_addr;
        wb_data <= wb_data;
      end

      if (dec_illegal && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end else begin
      wb_en <= 1'b0;
    end
  end

endmodule

// File: doc/dptr_pipe.md
DPTR_PIPE -- requirements
Module: dptr_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath and register width in bits (minimum 8).
REQ-002 The block SHALL have parameter IMEM_AW, default 6, meaning instruction-memory address width (depth 2**IMEM_AW words of 32 bits).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port run  input  1  meaning 1 = pipeline advances, 0 = pipeline frozen, load port enabled.
REQ-006 The block SHALL have port imem_we  input  1  meaning instruction-memory write strobe.
REQ-007 The block SHALL have port imem_addr  input  IMEM_AW  meaning load address.
REQ-008 The block SHALL have port imem_wdata  input  32  meaning load data.
REQ-009 The block SHALL have port pc  output  IMEM_AW  meaning current fetch address.
REQ-010 The block SHALL have ports wb_en (1), wb_addr (5) and wb_data (DATA_W), all outputs, meaning registered write-back event, destination register and value.
REQ-011 The block SHALL have port halted  output  1  meaning a halt instruction has executed.
REQ-012 The block SHALL have port err_cnt  output  8  meaning count of illegal instructions.

Function
REQ-013 Instruction format SHALL be opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0]; shamt is ignored.
REQ-014 With opcode 0x00, the block SHALL decode funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0); add/sub wrap modulo 2**DATA_W.
REQ-015 Opcode 0x3F SHALL be halt; any other opcode or funct SHALL be illegal, execute as no-op, and increment err_cnt, saturating at 255.
REQ-016 The block SHALL contain a 32 x DATA_W register file; register 0 reads 0 always, and writes to it are discarded (wb_en still pulses, wb_addr=0).
REQ-017 The pipeline SHALL have three stages: IF (IR <= imem[pc], pc <= pc+1), EX (register read, ALU, result latched), WB (register-file write, wb_* outputs).
REQ-018 An instruction fetched at edge n SHALL execute at edge n+1 and have wb_en=1 with its result from edge n+2 for exactly one cycle; steady-state throughput is one instruction per cycle.
REQ-019 When an EX source register equals a register being written in WB in the same cycle (nonzero), EX SHALL use the WB value (forwarding); no stalls exist.
REQ-020 pc SHALL wrap from 2**IMEM_AW-1 to 0.
REQ-021 Halt reaching EX SHALL set halted=1, freeze pc, and flush IF to no-op; the instruction ahead of it in WB completes; wb_en is 0 for halt itself.
REQ-022 Once halted, only reset SHALL clear halted; run has no further effect.
REQ-023 With run=0, all pipeline registers, pc and err_cnt SHALL hold, and wb_en SHALL be 0.
REQ-024 imem_we SHALL write imem[imem_addr] only when run=0; with run=1 it SHALL be ignored.
REQ-025 On run 0->1, the first fetch SHALL use the held pc.

Reset
REQ-026 rst_n=0 SHALL immediately clear pc, IR (to no-op), EX/WB registers, register file, wb_en, wb_addr, wb_data, halted and err_cnt, independent of clk.
REQ-027 Instruction memory SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-program SHALL drop in-flight instructions with no write-back after reset release; execution restarts at pc=0 on the first edge with rst_n=1 and run=1.

Verification
REQ-029 Load imem[0]=add r3,r0,r0 (0x00001820), run=1 -> wb_en=1, wb_addr=3, wb_data=0 two edges after first fetch.
REQ-030 Program with r1=5, r2=7 via preceding ops, then sub r3,r1,r2 followed immediately by slt r4,r3,r0 -> wb_data -2 for r3, then 1 for r4 (forwarding exercised).
REQ-031 halt at address 4 -> halted=1 after its EX edge, pc holds 6, no wb_en for instructions at 5+.
REQ-032 Word 0xFC00_0000 replaced by 0x0000_003F (illegal funct) x3 -> err_cnt=3, no register changes.
REQ-033 IMEM_AW=2, four no-ops, 6 cycles run -> pc sequence 0,1,2,3,0,1.
REQ-034 rst_n pulsed low mid-program -> all outputs 0 asynchronously, imem preserved, rerun reproduces identical wb_* trace.
